maze_path_player: RTL and testbench
===================================

// Module: maze_path_player
// PURPOSE
//  Downstream consumer of the maze datapath Move output. Buffers the solved path (2-bit moves,
//  popped from the queue while selMove drives Move) in a FIFO, then replays it on start at a fixed
//  pace. Each replayed step recomputes the mouse X/Y position and pulses a strobe for the display/LED stage.
// PARAMETERS
//  DEPTH  16  FIFO entries (power of 2, >=2); max path length accepted
//  PACE   4   clock cycles between replayed steps (>=1)
// PORTS
//  clk       in   1  single clock, rising edge
//  rst       in   1  reset, asynchronous, active-low
//  in_valid  in   1  move present on in_move (from datapath Move, qualified by controller)
//  in_move   in   2  move code: 00=X+1, 01=Y+1, 10=X-1, 11=Y-1
//  in_last   in   1  marks final move of path (qualified by in_valid)
//  in_ready  out  1  player accepts a move this cycle
//  start     in   1  begin replay (level sampled, acted on only in LOADED)
//  out_step  out  1  one-cycle pulse per replayed move
//  out_move  out  2  move code of most recent replayed step
//  out_x     out  4  current replay X position
//  out_y     out  4  current replay Y position
//  busy      out  1  high in PLAY
//  done      out  1  high in DONE
//  error     out  1  high in ERR (bounds violation, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): state=COLLECT, FIFO empty, out_x=out_y=0, out_move=00, in_ready=1,
//    out_step=busy=done=error=0, pace counter=0.
//  - Handshake: move written when in_valid&in_ready at clk edge. in_ready = (state==COLLECT) & !full.
//    FIFO full: in_ready=0, move held by producer; no drop, no overwrite.
//  - States:
//    COLLECT: accept moves; accepted in_last -> LOADED. in_last ignored unless accepted.
//    LOADED : in_ready=0; start=1 -> PLAY, pace counter loaded with PACE-1, out_x=out_y=0.
//    PLAY   : counter decrements each cycle; at 0: pop FIFO head, update position, out_move=head,
//             out_step=1 for that cycle, counter reloads PACE-1. First step PACE cycles after PLAY entry.
//             Pop that empties FIFO -> DONE next cycle (after its out_step).
//    DONE   : done=1, out_x/out_y hold final position; start=1 -> COLLECT (FIFO already empty).
//    ERR    : error=1, all outputs hold; left only by reset.
//  - start in COLLECT/PLAY ignored. in_valid outside COLLECT ignored (in_ready=0).
//  - Position arithmetic 4-bit unsigned; update per move code; both coordinates change only on a pop.
//  - FIFO: DEPTH entries, read/write pointers log2(DEPTH)+1 bits, full when MSBs differ and rest equal;
//    pointers wrap modulo 2*DEPTH. Write of DEPTH-th entry with in_last -> LOADED with full FIFO.
//  - Reset mid-PLAY: immediate return to reset state; buffered path discarded.
// CONFIGURATION
//  Macro PLAYER_BOUNDS_CHECK_EN:
//   defined  : a pop whose move takes X or Y below 0 or above 15 does not update position,
//              no out_step; next state ERR, error=1.
//   undefined: coordinates wrap modulo 16 (15+1=0, 0-1=15); ERR unreachable, error tied 0.
// TESTING
//  1 Reset: drive rst=0 mid-cycle -> all outputs at reset values immediately, in_ready=1.
//  2 Load 00,00,01(last), start, PACE=4 -> out_step at cycles 4,8,12 after PLAY entry; final (2,1); done=1.
//  3 Push 16 moves w/o last (DEPTH=16) -> in_ready=0 after 16th; 17th held; 16th-with-last -> LOADED.
//  4 Path 10(last) from (0,0): with PLAYER_BOUNDS_CHECK_EN -> error=1, pos (0,0), no out_step;
//    without -> out_x=15, done=1.
//  5 start asserted during COLLECT and in_valid during PLAY -> no state change, no FIFO write.
//  6 rst=0 after 2nd step of 5-move replay -> reset state; reload 01(last) -> replay ends at (0,1).

Source files
------------

// File: rtl/maze_path_player.sv
// Buffers a solved maze path (2-bit moves) in a FIFO and replays it at a fixed pace, tracking X/Y.
// Optional macro PLAYER_BOUNDS_CHECK_EN: out-of-range moves trap in ERR instead of wrapping mod 16.
module maze_path_player #(
  parameter int DEPTH = 16,
  parameter int PACE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic [1:0] in_move_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  input  logic       start_i,
  output logic       out_step_o,
  output logic [1:0] out_move_o,
  output logic [3:0] out_x_o,
  output logic [3:0] out_y_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PACE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_LOADED,
    S_PLAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q;
  logic [1:0]      mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      x_q, y_q;
  logic [3:0]      x_d, y_d;
  logic [1:0]      move_q;
  logic            step_q;
  logic            full, empty, wr_en, oob_hit;
  logic [1:0]      head;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign in_ready_o = (state_q == S_COLLECT) && !full;
  assign wr_en = in_valid_i && in_ready_o;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_move_i;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (head)
      2'b00:   x_d = x_q + 4'd1;
      2'b01:   y_d = y_q + 4'd1;
      2'b10:   x_d = x_q - 4'd1;
      default: y_d = y_q - 4'd1;
    endcase
  end

`ifdef PLAYER_BOUNDS_CHECK_EN
  always_comb begin
    oob_hit = 1'b0;
    case (head)
      2'b00:   oob_hit = (x_q == 4'hF);
      2'b01:   oob_hit = (y_q == 4'hF);
      2'b10:   oob_hit = (x_q == 4'h0);
      default: oob_hit = (y_q == 4'h0);
    endcase
  end
  assign error_o = (state_q == S_ERR);
`else
  assign oob_hit = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      x_q      <= 4'd0;
      y_q      <= 4'd0;
      move_q   <= 2'b00;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      case (state_q)
        S_COLLECT: begin
          if (wr_en && in_last_i) begin
            state_q <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (start_i) begin
            state_q <= S_PLAY;
            cnt_q   <= CNT_RELOAD;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
          end
        end
        S_PLAY: begin
          // Emptiness is checked first so DONE follows the final step by one cycle.
          if (empty) begin
            state_q <= S_DONE;
          end else if (cnt_q == '0) begin
            cnt_q    <= CNT_RELOAD;
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (oob_hit) begin
              state_q <= S_ERR;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              move_q <= head;
              step_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          if (start_i) begin
            state_q <= S_COLLECT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_step_o = step_q;
  assign out_move_o = move_q;
  assign out_x_o    = x_q;
  assign out_y_o    = y_q;
  assign busy_o     = (state_q == S_PLAY);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_maze_path_player.sv
// Scoreboard bench for maze_path_player: expected steps are queued as moves are loaded and
// popped as the player replays them.
module tb_maze_path_player;
  localparam int DEPTH = 16;
  localparam int PACE  = 4;
`ifdef PLAYER_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] m;
    logic [3:0] x;
    logic [3:0] y;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_move = 2'b00;
  logic       in_last = 1'b0;
  logic       start = 1'b0;
  logic       in_ready, out_step, busy, done, error;
  logic [1:0] out_move;
  logic [3:0] out_x, out_y;

  int    vec_cnt = 0;
  int    err_cnt = 0;
  logic [3:0] mx = 4'd0, my = 4'd0;
  bit    merr = 1'b0;
  step_t exp_q[$];

  localparam logic [14:0] RESET_VEC = 15'b1_0_00_0000_0000_0_0_0;

  maze_path_player #(.DEPTH(DEPTH), .PACE(PACE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_move_i(in_move), .in_last_i(in_last), .in_ready_o(in_ready),
    .start_i(start), .out_step_o(out_step), .out_move_o(out_move),
    .out_x_o(out_x), .out_y_o(out_y), .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mx = 4'd0; my = 4'd0; merr = 1'b0;
    exp_q.delete();
  endtask

  // Drives one move through the handshake and queues the step the player should later replay.
  task automatic push_move(input logic [1:0] m, input logic last);
    int n = 0;
    int tx = int'(mx);
    int ty = int'(my);
    step_t e;
    in_valid = 1'b1; in_move = m; in_last = last;
    while (!in_ready && n < 50) begin
      tick(); n++;
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL push_accept: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    case (m)
      2'b00:   tx = tx + 1;
      2'b01:   ty = ty + 1;
      2'b10:   tx = tx - 1;
      default: ty = ty - 1;
    endcase
    if (!merr) begin
      if (BOUNDS && (tx < 0 || tx > 15 || ty < 0 || ty > 15)) begin
        merr = 1'b1;
      end else begin
        mx = tx[3:0]; my = ty[3:0];
        e.m = m; e.x = mx; e.y = my;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_replay(input int max_steps, output int steps);
    int cyc = 0;
    bit fin = 1'b0;
    step_t e;
    steps = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL play_entry: busy=%b required 1", busy);
    end
    while (cyc < 400 && !fin) begin
      tick(); cyc++;
      if (out_step === 1'b1) begin
        steps++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL step_extra: got move %b at (%0d,%0d), none expected", out_move, out_x, out_y);
        end else begin
          e = exp_q.pop_front();
          if ({out_move, out_x, out_y} !== {e.m, e.x, e.y}) begin
            err_cnt++;
            $display("FAIL step_data: move %b pos (%0d,%0d) required move %b pos (%0d,%0d)",
                     out_move, out_x, out_y, e.m, e.x, e.y);
          end
        end
        vec_cnt++;
        if (cyc != PACE * steps || done !== 1'b0) begin
          err_cnt++;
          $display("FAIL step_time: step %0d at cycle %0d done=%b required cycle %0d done=0",
                   steps, cyc, done, PACE * steps);
        end
        if (steps == max_steps) fin = 1'b1;
      end
      if (done === 1'b1 || error === 1'b1) fin = 1'b1;
    end
    if (!fin) begin
      vec_cnt++; err_cnt++;
      $display("FAIL replay_timeout: %0d steps in %0d cycles, no done/error", steps, cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({in_ready, out_step, out_move, out_x, out_y, busy, done, error} !== RESET_VEC) begin
      err_cnt++; $display("FAIL reset_values: got %b required %b",
        {in_ready, out_step, out_move, out_x, out_y, busy, done, error}, RESET_VEC);
    end
    push_move(2'b00, 1'b1);
    vec_cnt++;
    if (in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL loaded_ready: in_ready=%b required 0", in_ready);
    end
    #3 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({in_ready, out_step, out_move, out_x, out_y, busy, done, error} !== RESET_VEC) begin
      err_cnt++; $display("FAIL async_reset: got %b required %b",
        {in_ready, out_step, out_move, out_x, out_y, busy, done, error}, RESET_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    mx = 4'd0; my = 4'd0; merr = 1'b0; exp_q.delete();
  endtask

  task automatic test_replay();
    int s;
    do_reset();
    push_move(2'b00, 1'b0);
    push_move(2'b00, 1'b0);
    push_move(2'b01, 1'b1);
    run_replay(99, s);
    vec_cnt++;
    if (s != 3 || done !== 1'b1 || busy !== 1'b0 || out_x !== 4'd2 || out_y !== 4'd1) begin
      err_cnt++; $display("FAIL replay_final: steps=%0d done=%b busy=%b pos (%0d,%0d) required 3,1,0,(2,1)",
                          s, done, busy, out_x, out_y);
    end
    tick(); tick();
    vec_cnt++;
    if (done !== 1'b1 || out_x !== 4'd2 || out_y !== 4'd1 || out_step !== 1'b0) begin
      err_cnt++; $display("FAIL done_hold: done=%b step=%b pos (%0d,%0d) required 1,0,(2,1)",
                          done, out_step, out_x, out_y);
    end
    start = 1'b1; tick(); start = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      err_cnt++; $display("FAIL done_to_collect: in_ready=%b done=%b required 1,0", in_ready, done);
    end
  endtask

  task automatic test_full();
    logic [1:0] pat [16] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3,
                             2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3};
    int s;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_move(pat[i], 1'b0);
    in_valid = 1'b1; in_move = 2'b11; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        err_cnt++; $display("FAIL full_hold: in_ready=%b busy=%b required 0,0", in_ready, busy);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) push_move(pat[i], 1'b0);
    push_move(pat[DEPTH-1], 1'b1);
    vec_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++; $display("FAIL full_loaded: in_ready=%b busy=%b done=%b required 0,0,0", in_ready, busy, done);
    end
    run_replay(99, s);
    vec_cnt++;
    if (s != DEPTH || done !== 1'b1 || out_x !== 4'd4 || out_y !== 4'd4) begin
      err_cnt++; $display("FAIL full_replay: steps=%0d done=%b pos (%0d,%0d) required 16,1,(4,4)",
                          s, done, out_x, out_y);
    end
  endtask

  task automatic test_bounds();
    int s;
    do_reset();
    push_move(2'b10, 1'b1);
    run_replay(99, s);
    vec_cnt++;
    if (BOUNDS) begin
      if (s != 0 || error !== 1'b1 || done !== 1'b0 || out_x !== 4'd0 || out_y !== 4'd0) begin
        err_cnt++; $display("FAIL bounds_trap: steps=%0d error=%b done=%b pos (%0d,%0d) required 0,1,0,(0,0)",
                            s, error, done, out_x, out_y);
      end
    end else begin
      if (s != 1 || error !== 1'b0 || done !== 1'b1 || out_x !== 4'd15 || out_y !== 4'd0) begin
        err_cnt++; $display("FAIL bounds_wrap: steps=%0d error=%b done=%b pos (%0d,%0d) required 1,0,1,(15,0)",
                            s, error, done, out_x, out_y);
      end
    end
  endtask

  task automatic test_ignore();
    int s;
    do_reset();
    start = 1'b1;
    tick(); tick(); tick();
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++; $display("FAIL start_in_collect: in_ready=%b busy=%b done=%b required 1,0,0", in_ready, busy, done);
    end
    start = 1'b0;
    push_move(2'b00, 1'b0);
    push_move(2'b01, 1'b1);
    in_valid = 1'b1; in_move = 2'b11; in_last = 1'b1;
    run_replay(99, s);
    vec_cnt++;
    if (s != 2 || done !== 1'b1 || in_ready !== 1'b0 || out_x !== 4'd1 || out_y !== 4'd1) begin
      err_cnt++; $display("FAIL valid_in_play: steps=%0d done=%b in_ready=%b pos (%0d,%0d) required 2,1,0,(1,1)",
                          s, done, in_ready, out_x, out_y);
    end
    in_valid = 1'b0; in_last = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    mx = 4'd0; my = 4'd0;
    push_move(2'b01, 1'b1);
    run_replay(99, s);
    vec_cnt++;
    if (s != 1 || done !== 1'b1 || out_x !== 4'd0 || out_y !== 4'd1) begin
      err_cnt++; $display("FAIL no_stray_write: steps=%0d done=%b pos (%0d,%0d) required 1,1,(0,1)",
                          s, done, out_x, out_y);
    end
  endtask

  task automatic test_reset_mid_play();
    int s;
    do_reset();
    push_move(2'b00, 1'b0);
    push_move(2'b01, 1'b0);
    push_move(2'b00, 1'b0);
    push_move(2'b01, 1'b0);
    push_move(2'b00, 1'b1);
    run_replay(2, s);
    vec_cnt++;
    if (s != 2 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL mid_play: steps=%0d busy=%b required 2,1", s, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({in_ready, out_step, out_move, out_x, out_y, busy, done, error} !== RESET_VEC) begin
      err_cnt++; $display("FAIL mid_play_reset: got %b required %b",
        {in_ready, out_step, out_move, out_x, out_y, busy, done, error}, RESET_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    mx = 4'd0; my = 4'd0; merr = 1'b0; exp_q.delete();
    push_move(2'b01, 1'b1);
    run_replay(99, s);
    vec_cnt++;
    if (s != 1 || done !== 1'b1 || out_x !== 4'd0 || out_y !== 4'd1) begin
      err_cnt++; $display("FAIL reload_after_reset: steps=%0d done=%b pos (%0d,%0d) required 1,1,(0,1)",
                          s, done, out_x, out_y);
    end
  endtask

  initial begin
    test_reset();
    test_replay();
    test_full();
    test_bounds();
    test_ignore();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
